// File: rtl/extrinsic_pipe_razor1_if.sv
// rtl/extrinsic_pipe_razor1_if.sv - epsilon-to-extrinsic stage signal bundle
interface extrinsic_pipe_razor1_if #(
  parameter int M = 6
);
  logic             Start;
  logic             Enable;
  logic             Error_previous_Epsilon;
  logic [4:1][M:0]  epsilon;
  logic [M-1:0]     b_a;
  logic [M-1:0]     b_e;
  logic             b_hat;
  logic             Error_current_Extrinsic;
  logic             Busy;
  logic             Done;
  logic [7:0]       ErrCount;

  modport master (
    output Start, Enable, Error_previous_Epsilon, epsilon, b_a,
    input  b_e, b_hat, Error_current_Extrinsic, Busy, Done, ErrCount
  );

  modport slave (
    input  Start, Enable, Error_previous_Epsilon, epsilon, b_a,
    output b_e, b_hat, Error_current_Extrinsic, Busy, Done, ErrCount
  );
endinterface

// File: rtl/extrinsic_pipe_razor1.sv
// rtl/extrinsic_pipe_razor1.sv - saturated extrinsic LLR, hard decision and iteration control
module extrinsic_pipe_razor1 #(
  parameter int M     = 6,
  parameter int I_MAX = 8,
  parameter int IW    = 4
) (
  input  logic Clock,
  input  logic nReset,
  input  logic nClear,
  extrinsic_pipe_razor1_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic signed [M+1:0] SAT_HI = (M+2)'(2 ** (M - 1) - 1);
  localparam logic signed [M+1:0] SAT_LO = (M+2)'(-(2 ** (M - 1)));

  state_t                state, state_nx;
  logic [IW-1:0]         cnt, cnt_nx;
  logic signed [M-1:0]   be_q, be_nx;
  logic                  bhat_q, bhat_nx;
  logic                  errf_q, errf_nx;
  logic [7:0]            errc_q, errc_nx;

  logic signed [M:0]     e1, e2, e3, e4, pos, neg;
  logic signed [M+1:0]   d;
  logic signed [M-1:0]   be_dp;
  logic signed [M:0]     p;
  logic                  bhat_dp;
  logic                  upd, sup;

  assign e1  = $signed(bus.epsilon[1]);
  assign e2  = $signed(bus.epsilon[2]);
  assign e3  = $signed(bus.epsilon[3]);
  assign e4  = $signed(bus.epsilon[4]);
  assign pos = (e1 > e2) ? e1 : e2;
  assign neg = (e3 > e4) ? e3 : e4;
  assign d   = $signed({pos[M], pos}) - $signed({neg[M], neg});

  // Clamp the M+2 bit difference into the M bit signed extrinsic range
  always_comb begin
    be_dp = d[M-1:0];
    if (d > SAT_HI)
      be_dp = SAT_HI[M-1:0];
    else if (d < SAT_LO)
      be_dp = SAT_LO[M-1:0];
  end

  // A-posteriori sum is deliberately unsaturated; only its sign and zero-ness matter
  assign p       = $signed({bus.b_a[M-1], bus.b_a}) + $signed({be_dp[M-1], be_dp});
  assign bhat_dp = !p[M] && (p != '0);

  // Razor error only matters on an enabled RUN cycle
  assign upd = (state == RUN) && bus.Enable && !bus.Error_previous_Epsilon;
  assign sup = (state == RUN) && bus.Enable && bus.Error_previous_Epsilon;

  // Next-state and datapath update selection; a restart takes precedence over the update
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    be_nx    = be_q;
    bhat_nx  = bhat_q;
    errf_nx  = 1'b0;
    errc_nx  = errc_q;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (bus.Start) begin
          cnt_nx = '0;
        end else if (upd) begin
          be_nx   = be_dp;
          bhat_nx = bhat_dp;
          cnt_nx  = cnt + IW'(1);
          if (cnt == IW'(I_MAX - 1))
            state_nx = DONE;
        end
        if (sup) begin
          errf_nx = 1'b1;
          if (errc_q != 8'hFF)
            errc_nx = errc_q + 8'd1;
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; frame clear behaves like reset but keeps the error tally
  always_ff @(posedge Clock) begin
    if (!nReset || !nClear) begin
      state  <= IDLE;
      cnt    <= '0;
      be_q   <= '0;
      bhat_q <= 1'b0;
      errf_q <= 1'b0;
      errc_q <= nReset ? errc_q : 8'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      be_q   <= be_nx;
      bhat_q <= bhat_nx;
      errf_q <= errf_nx;
      errc_q <= errc_nx;
    end
  end

  assign bus.b_e                     = be_q;
  assign bus.b_hat                   = bhat_q;
  assign bus.Error_current_Extrinsic = errf_q;
  assign bus.Busy                    = (state == RUN);
  assign bus.Done                    = (state == DONE);
  assign bus.ErrCount                = errc_q;

endmodule
